// File: rtl/pspl_comm_regs.sv
// AXI4-Lite slave exposing four RW control registers and one RO status word to the PL.
// Latency: a write commits one edge after both AW and W are buffered; read data one cycle after AR.
// Backpressure: AW/W stall while their buffer is full or B is pending; AR stalls while R is pending.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET  clock, synchronous active-high reset
//   S_AXI_AW* / W* / B*        write address, data and response channels (AWPROT ignored)
//   S_AXI_AR* / R*             read address and data channels (ARPROT ignored)
//   pl_reg0..pl_reg3           current register contents (0x00/0x04/0x08/0x0C)
//   pl_status                  status word, readable at 0x10, sampled at the AR handshake
//   pl_wr_pulse                one-cycle strobe per register when a write commits to it
// Build option: define PSPL_COMM_WSTRB_EN to honour WSTRB byte lanes; otherwise whole words are written.
module pspl_comm_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   pl_reg3,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   pl_status,
  output logic [3:0]                      pl_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t        r_state;
  logic            rdy_en;      // low through reset and the first edge after it
  logic            aw_full;
  logic            w_full;
  logic [2:0]      aw_idx;      // word index, address bits [4:2]
  logic [DW-1:0]   w_dat;
  logic [SW-1:0]   w_strb;
  logic [DW-1:0]   regs [4];
  logic            commit;
  logic [DW-1:0]   wr_val;
  logic [DW-1:0]   rd_word;
  logic            rd_err;
  logic            unused_ok;

  assign S_AXI_AWREADY = rdy_en & ~aw_full & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = rdy_en & ~w_full  & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = rdy_en & (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign commit        = aw_full & w_full;

  assign pl_reg0 = regs[0];
  assign pl_reg1 = regs[1];
  assign pl_reg2 = regs[2];
  assign pl_reg3 = regs[3];

`ifdef PSPL_COMM_WSTRB_EN
  // Byte lanes without a strobe keep the current register contents.
  always_comb begin
    wr_val = regs[aw_idx[1:0]];
    for (int k = 0; k < SW; k++) begin
      if (w_strb[k]) wr_val[8*k +: 8] = w_dat[8*k +: 8];
    end
  end
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
`else
  assign wr_val    = w_dat;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, w_strb};
`endif

  // Write path: independent AW/W holding buffers, commit once both are full.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rdy_en       <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx       <= '0;
      w_dat        <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      pl_wr_pulse  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      rdy_en      <= 1'b1;
      pl_wr_pulse <= '0;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_dat  <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // Readies are low while BVALID is set, so a commit never overlaps a B handshake.
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        if (!aw_idx[2]) begin
          regs[aw_idx[1:0]]        <= wr_val;
          pl_wr_pulse[aw_idx[1:0]] <= 1'b1;
          S_AXI_BRESP              <= RESP_OKAY;
        end else begin
          S_AXI_BRESP <= RESP_SLVERR;
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rd_word = regs[0];
      3'd1:    rd_word = regs[1];
      3'd2:    rd_word = regs[2];
      3'd3:    rd_word = regs[3];
      3'd4:    rd_word = pl_status;
      default: rd_err  = 1'b1;
    endcase
  end

  // Read path: data captured at the AR handshake, so a same-edge commit is not visible.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && rdy_en) begin
            S_AXI_RDATA <= rd_word;
            S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pspl_comm_regs.sv
module tb_pspl_comm_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] pl_reg0, pl_reg1, pl_reg2, pl_reg3;
  logic [31:0] pl_status = '0;
  logic [3:0]  pl_wr_pulse;

  pspl_comm_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pl_reg0(pl_reg0), .pl_reg1(pl_reg1), .pl_reg2(pl_reg2), .pl_reg3(pl_reg3),
    .pl_status(pl_status), .pl_wr_pulse(pl_wr_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [1:0] resp; logic [3:0][31:0] regs; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  bexp_t           b_q[$];
  rexp_t           r_q[$];
  logic [3:0]      p_q[$];
  logic [3:0][31:0] mdl = '0;   // register contents committed so far

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`ifndef PSPL_COMM_WSTRB_EN
    m = '1;
`endif
    return (old & ~m) | (nw & m);
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (b_q.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
      else begin
        bexp_t e;
        e = b_q.pop_front();
        chk("bresp", 32'(bresp), 32'(e.resp));
        chk("b_pl_reg0", pl_reg0, e.regs[0]);
        chk("b_pl_reg1", pl_reg1, e.regs[1]);
        chk("b_pl_reg2", pl_reg2, e.regs[2]);
        chk("b_pl_reg3", pl_reg3, e.regs[3]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (r_q.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
      else begin
        rexp_t e;
        e = r_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", 32'(rresp), 32'(e.resp));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pl_wr_pulse !== 4'b0) begin
      if (p_q.size() == 0) chk("wr_pulse_unexpected", 32'(pl_wr_pulse), 32'd0);
      else chk("wr_pulse", 32'(pl_wr_pulse), 32'(p_q.pop_front()));
    end
  end

  // Response stability and ready gating while responses are pending.
  logic        b_hold = 1'b0, r_hold = 1'b0;
  logic [1:0]  b_prev = '0, r_prev_resp = '0;
  logic [31:0] r_prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold) begin
        chk("bvalid_hold", 32'(bvalid), 32'd1);
        chk("bresp_hold", 32'(bresp), 32'(b_prev));
      end
      if (r_hold) begin
        chk("rvalid_hold", 32'(rvalid), 32'd1);
        chk("rdata_hold", rdata, r_prev_data);
        chk("rresp_hold", 32'(rresp), 32'(r_prev_resp));
      end
      if (bvalid) chk("aw_w_ready_during_b", 32'({awready, wready}), 32'd0);
      if (rvalid) chk("arready_during_r", 32'(arready), 32'd0);
      b_hold = bvalid && !bready;
      b_prev = bresp;
      r_hold = rvalid && !rready;
      r_prev_data = rdata;
      r_prev_resp = rresp;
    end
  end

  // ---------------- drivers (entered and left just after a rising edge) ----------------
  task automatic send_aw(input logic [4:0] a, input int dly, output int hs);
    int n;
    if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    chk("aw_ready_wait", 32'(awready), 32'd1);
    hs = cyc;
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
    int n;
    if (dly > 0) begin repeat (dly) @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!wready && n < 50);
    chk("w_ready_wait", 32'(wready), 32'd1);
    hs = cyc;
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int d_aw, input int d_w, input int bdly, input bit w_pre);
    bexp_t e;
    int h_aw, h_w, last, n;
    e.regs = mdl;
    if (addr[4] == 1'b0) begin
      e.resp = 2'b00;
      e.regs[addr[3:2]] = merge(mdl[addr[3:2]], data, strb);
      p_q.push_back(4'b0001 << addr[3:2]);
    end else begin
      e.resp = 2'b10;
    end
    b_q.push_back(e);
    h_aw = 0;
    h_w = -10;
    bready = (bdly == 0);
    fork
      send_aw(addr, d_aw, h_aw);
      if (!w_pre) send_w(data, strb, d_w, h_w);
    join
    last = (h_aw > h_w) ? h_aw : h_w;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    chk("b_latency", 32'(cyc), 32'(last + 2));
    mdl = e.regs;
    if (bdly > 0) begin repeat (bdly) @(posedge clk); #1 bready = 1'b1; @(negedge clk); end
    n = 0;
    while (!(bvalid && bready) && n < 50) begin @(negedge clk); n++; end
    chk("b_handshake", 32'(bvalid & bready), 32'd1);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] st, input int rdly, output int hs);
    rexp_t e;
    int n;
    pl_status = st; araddr = addr; arvalid = 1'b1; rready = (rdly == 0); n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    chk("ar_ready_wait", 32'(arready), 32'd1);
    hs = cyc;
    if (addr[4:2] < 3'd4)       begin e.data = mdl[addr[3:2]]; e.resp = 2'b00; end
    else if (addr[4:2] == 3'd4) begin e.data = st;             e.resp = 2'b00; end
    else                        begin e.data = 32'd0;          e.resp = 2'b10; end
    r_q.push_back(e);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", 32'(rvalid), 32'd1);
    if (rdly > 0) begin repeat (rdly) @(posedge clk); #1 rready = 1'b1; @(negedge clk); end
    n = 0;
    while (!(rvalid && rready) && n < 50) begin @(negedge clk); n++; end
    chk("r_handshake", 32'(rvalid & rready), 32'd1);
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_regs", pl_reg0 | pl_reg1 | pl_reg2 | pl_reg3, 32'd0);
    chk("rst_pulse", 32'(pl_wr_pulse), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    reset_checks();
    @(posedge clk); #1 rst = 1'b0;
    mdl = '0;
    @(negedge clk);
    chk("ready_after_release_0", 32'({awready, wready, arready}), 32'd0);
    @(negedge clk);
    chk("ready_after_release_1", 32'({awready, wready, arready}), 32'd7);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int h, h1, h2;
    logic [31:0] exp35;

    apply_reset(3);

    for (int i = 0; i < 4; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 1'b0);
    chk("basic_pl_reg0", pl_reg0, 32'h1);
    chk("basic_pl_reg1", pl_reg1, 32'h2);
    chk("basic_pl_reg2", pl_reg2, 32'h3);
    chk("basic_pl_reg3", pl_reg3, 32'h4);
    for (int i = 0; i < 4; i++) do_read(5'(i * 4), 32'h0, i, h);

    do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, 1'b0);   // W three cycles ahead of AW
    chk("w_first_pl_reg2", pl_reg2, 32'hDEADBEEF);

    do_write(5'h00, 32'h0BAD_F00D, 4'hF, 0, 2, 5, 1'b0);  // B held off for 5 cycles
    do_read(5'h10, 32'hA5A5_0001, 1, h);
    do_read(5'h18, 32'h1234_5678, 0, h);
    do_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b0);

    do_write(5'h04, 32'h11223344, 4'hF, 1, 0, 0, 1'b0);
    do_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 1, 0, 1'b0);
`ifdef PSPL_COMM_WSTRB_EN
    exp35 = 32'h11BB33DD;
`else
    exp35 = 32'hAABBCCDD;
`endif
    chk("strobe_pl_reg1", pl_reg1, exp35);
    do_read(5'h04, 32'h0, 0, h);

    // AR handshake lands on the commit edge of a write to the same register.
    fork
      do_write(5'h08, 32'h5555AAAA, 4'hF, 0, 0, 0, 1'b0);
      begin @(posedge clk); #1; do_read(5'h08, 32'h0, 0, h); end
    join

    do_read(5'h00, 32'h0, 0, h1);
    do_read(5'h0C, 32'h0, 0, h2);
    chk("ar_back_to_back", 32'(h2 - h1), 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom(), 4'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'b0);
      else
        do_read(a, $urandom(), $urandom_range(0, 3), h);
    end

    // Reset with only AW buffered: the address must be discarded.
    send_aw(5'h0C, 0, h);
    apply_reset(2);
    send_w(32'hCAFE0123, 4'hF, 0, h);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_commit_after_reset", 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1;
    do_write(5'h04, 32'hCAFE0123, 4'hF, 0, 0, 0, 1'b1);
    do_read(5'h0C, 32'h0, 0, h);

    repeat (4) @(posedge clk);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);
    chk("r_queue_drained", 32'(r_q.size()), 32'd0);
    chk("pulse_queue_drained", 32'(p_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pspl_comm_regs.md
PSPL_COMM_REGS -- requirements
Module: pspl_comm_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, default 5, byte address width; decode uses bits [4:2].
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic is on the rising edge.
REQ-004 S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1, and AWREADY  out  1: write address channel; AWPROT is ignored.
REQ-006 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1, and WREADY  out  1: write data channel.
REQ-007 S_AXI_BRESP/BVALID  out  2/1, and BREADY  in  1: write response channel.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1, and ARREADY  out  1: read address channel; ARPROT is ignored.
REQ-009 S_AXI_RDATA/RRESP/RVALID  out  32/2/1, and RREADY  in  1: read data channel.
REQ-010 pl_reg0..pl_reg3  out  32 each: current contents of registers 0x00/0x04/0x08/0x0C, driven to PL.
REQ-011 pl_status  in  32: PL status word, readable at 0x10.
REQ-012 pl_wr_pulse  out  4: bit n is high for exactly 1 cycle when a write commits to register n.

Function
REQ-013 Register map:
  - 0x00, 0x04, 0x08, 0x0C: RW regs 0..3.
  - 0x10: RO pl_status, sampled at the AR handshake.
  - 0x14-0x1C: reserved.
REQ-014 AW and W channels are accepted independently into one-entry holding buffers:
  - AWREADY = 1 iff the AW buffer is empty and BVALID = 0.
  - WREADY = 1 iff the W buffer is empty and BVALID = 0.
REQ-015 AW and W may arrive in the same cycle or in either order with any gap; the commit waits until both buffers are full.
REQ-016 Commit occurs on the edge after both buffers become full:
  - register updated and pl_wr_pulse bit set on that edge;
  - BVALID asserted on that edge;
  - both buffers cleared on that edge.
REQ-017 Write latency is 1 cycle from the cycle in which the last of AW/W handshakes to BVALID.
REQ-018 BVALID and BRESP are held stable until BREADY = 1; BVALID deasserts on the edge where BVALID & BREADY.
REQ-019 BRESP is:
  - 2'b00 OKAY for 0x00-0x0C;
  - 2'b10 SLVERR for 0x10-0x1C, with no register change and no pl_wr_pulse.
REQ-020 Read state machine states are R_IDLE and R_DATA:
  - R_IDLE: ARREADY = 1; ARVALID = 1 causes RDATA/RRESP to be registered and the state to go to R_DATA on that edge.
  - R_DATA: ARREADY = 0; RVALID = 1; on RREADY = 1 the state returns to R_IDLE.
REQ-021 Read latency is 1 cycle from the AR handshake to RVALID; RDATA/RRESP are stable while RVALID = 1.
REQ-022 Read response is:
  - 0x00-0x10: OKAY;
  - 0x14-0x1C: RDATA = 0, RRESP = SLVERR.
REQ-023 Read and write paths operate concurrently.
REQ-024 If an AR handshake and a commit to the same register occur on the same edge, the read returns the pre-commit value.
REQ-025 Back-to-back operation:
  - A new AR may be accepted in the cycle after the R handshake, giving one transfer per 2 cycles.
  - Writes follow the same rule against the B handshake.

Reset
REQ-026 While S_AXI_ARESET = 1 at an edge, all of the following are forced:
  - AWREADY = WREADY = ARREADY = BVALID = RVALID = 0;
  - BRESP = RRESP = 0, RDATA = 0;
  - pl_reg0..3 = 0, pl_wr_pulse = 0;
  - holding buffers empty, read state R_IDLE.
REQ-027 The ready signals reach their REQ-014/REQ-020 values on the first edge after reset is released.
REQ-028 Reset mid-transaction discards buffered AW/W and any pending B/R response; the outstanding transfer is lost and no commit occurs.

Configuration
REQ-029 PSPL_COMM_WSTRB_EN controls byte-strobe handling:
  - Defined: only bytes with WSTRB[k] = 1 are written; WSTRB = 0 commits nothing to the register, but still returns OKAY and pulses pl_wr_pulse.
  - Undefined: WSTRB is ignored and all 32 bits are written.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x00-0x0C, then read back 0x00-0x0C -> RDATA 0x1,0x2,0x3,0x4, all OKAY, pl_reg0..3 match.
REQ-031 W (0xDEADBEEF) issued 3 cycles before AW (0x08) -> a single commit, pl_reg2 = 0xDEADBEEF, BVALID 1 cycle after the AW handshake, pl_wr_pulse = 4'b0100 for 1 cycle.
REQ-032 BREADY held low 5 cycles after a write -> BVALID/BRESP held, and AWREADY = WREADY = 0 throughout.
REQ-033 pl_status = 0xA5A5_0001 with a read of 0x10 -> 0xA5A5_0001 OKAY.
REQ-034 Reserved and read-only accesses:
  - Read of 0x18 -> 0, SLVERR.
  - Write to 0x10 -> SLVERR, and all pl_reg unchanged.
REQ-035 With PSPL_COMM_WSTRB_EN defined, pl_reg1 = 0x11223344, then write 0xAABBCCDD with WSTRB 4'b0101 -> pl_reg1 = 0x11BB33DD; without the macro -> 0xAABBCCDD.
